micro_sequencer: RTL

- Parametrised next-generation microprogram sequencer; generates the next control-store address each cycle.
- Adds to the 2-bit-op sequencer:
  - wider op set
  - condition-qualified branches
  - a loop counter
  - a configurable-depth subroutine stack with full/empty/error flags
  - a hold mode
- Sits between the microinstruction pipeline register (which supplies op, din, cond_sel) and the control-store ROM (addressed combinationally by yout).

---
 rtl/micro_seq_pkg.sv | 18 +
 rtl/seq_stack.sv | 60 ++++++
 rtl/micro_sequencer.sv | 105 ++++++++++
 3 files changed

// File: rtl/micro_seq_pkg.sv
// Shared definitions for the microprogram sequencer: op encodings and a width helper.
package micro_seq_pkg;

    localparam logic [2:0] OP_CONT = 3'd0;
    localparam logic [2:0] OP_JUMP = 3'd1;
    localparam logic [2:0] OP_CJMP = 3'd2;
    localparam logic [2:0] OP_JSR  = 3'd3;
    localparam logic [2:0] OP_CJSR = 3'd4;
    localparam logic [2:0] OP_RET  = 3'd5;
    localparam logic [2:0] OP_LDCT = 3'd6;
    localparam logic [2:0] OP_LOOP = 3'd7;

    // Index width for n selectable items, never narrower than one bit.
    function automatic int clogw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_stack.sv
// Subroutine return-address LIFO; pushes when full and pops when empty are dropped
// and reported on single-cycle overflow/underflow strobes.
module seq_stack #(
    parameter int AW    = 12,
    parameter int DEPTH = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [AW-1:0] data_i,
    output logic [AW-1:0] tos_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          overflow_o,
    output logic          underflow_o
);

    localparam int SPW = $clog2(DEPTH) + 1;
    localparam int IW  = SPW - 1;

    logic [SPW-1:0] sp_q, sp_d;
    logic [AW-1:0]  mem_q [DEPTH];
    logic [IW-1:0]  wrIdx, tosIdx;
    logic           doPush, doPop;

    assign full_o      = (sp_q == SPW'(DEPTH));
    assign empty_o     = (sp_q == '0);
    assign wrIdx       = sp_q[IW-1:0];
    assign tosIdx      = wrIdx - IW'(1);
    assign tos_o       = mem_q[tosIdx];
    assign doPush      = push_i & ~full_o;
    assign doPop       = pop_i & ~empty_o;
    assign overflow_o  = push_i & full_o;
    assign underflow_o = pop_i & empty_o;

    always_comb begin
        sp_d = sp_q;
        if (doPush) begin
            sp_d = sp_q + SPW'(1);
        end else if (doPop) begin
            sp_d = sp_q - SPW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sp_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sp_q <= sp_d;
            if (doPush) begin
                mem_q[wrIdx] <= data_i;
            end
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// Next-address generator for the control store: combinational address select from
// op/din/condition plus registered fetch address, loop counter and subroutine stack.
module micro_sequencer
    import micro_seq_pkg::*;
#(
    parameter int  AW    = 12,
    parameter int  DEPTH = 4,
    parameter int  NCOND = 4,
    localparam int CSW   = clogw(NCOND)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             hold,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    din,
    input  logic [NCOND-1:0] cond,
    input  logic [CSW-1:0]   cond_sel,
    input  logic             cond_pol,
    output logic [AW-1:0]    yout,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             stack_err
);

    logic [AW-1:0] addr_q, cnt_q, cnt_d, upc, nextAddr, tos;
    logic          stackErr_q, condBit, condHit;
    logic          push, pop, overflow, underflow;

    assign upc = addr_q + AW'(1);

    // A cond_sel beyond the implemented inputs reads as a deasserted condition.
    always_comb begin
        condBit = 1'b0;
        if (32'(cond_sel) < 32'(NCOND)) begin
            condBit = cond[cond_sel];
        end
        condHit = condBit ^ cond_pol;
    end

    always_comb begin
        nextAddr = upc;
        cnt_d    = cnt_q;
        push     = 1'b0;
        pop      = 1'b0;
        if (hold) begin
            nextAddr = addr_q;
        end else begin
            case (op)
                OP_JUMP: nextAddr = din;
                OP_CJMP: if (condHit) nextAddr = din;
                OP_JSR: begin
                    nextAddr = din;
                    push     = 1'b1;
                end
                OP_CJSR: if (condHit) begin
                    nextAddr = din;
                    push     = 1'b1;
                end
                // An empty-stack return falls through like CONT.
                OP_RET: begin
                    pop = 1'b1;
                    if (!stack_empty) nextAddr = tos;
                end
                OP_LDCT: cnt_d = din;
                OP_LOOP: if (cnt_q != '0) begin
                    nextAddr = din;
                    cnt_d    = cnt_q - AW'(1);
                end
                default: ;
            endcase
        end
    end

    assign yout      = reset ? nextAddr : '0;
    assign stack_err = stackErr_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q     <= '0;
            cnt_q      <= '0;
            stackErr_q <= 1'b0;
        end else begin
            addr_q     <= nextAddr;
            cnt_q      <= cnt_d;
            stackErr_q <= stackErr_q | overflow | underflow;
        end
    end

    seq_stack #(
        .AW   (AW),
        .DEPTH(DEPTH)
    ) uStack (
        .clock      (clock),
        .reset      (reset),
        .push_i     (push),
        .pop_i      (pop),
        .data_i     (upc),
        .tos_o      (tos),
        .full_o     (stack_full),
        .empty_o    (stack_empty),
        .overflow_o (overflow),
        .underflow_o(underflow)
    );

endmodule
